// File: rtl/overlap_sched_117bit.sv
// overlap_sched_117bit: collects four 117-bit GF(2) partial products and
// interleaves them into one 235-bit overlap-combined product.
`default_nettype none

module overlap_sched_117bit #(
  parameter int N = 118
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_pp_valid,
  output logic           o_pp_ready,
  input  logic [N-2:0]   i_pp_data,
  input  logic           i_pp_last,
  input  logic           i_abort,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [2*N-2:0] o_out_data,
  output logic [1:0]     o_beat_cnt,
  output logic           o_proto_err
);

  localparam int c_PW = N - 1;
  localparam int c_RW = 2 * N - 1;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_DONE    = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_PW-1:0]   r_slot1;
  logic [c_PW-1:0]   r_slot2;
  logic [c_PW-1:0]   r_slot3;
  logic [1:0]        r_beat_cnt;
  logic [c_RW-1:0]   r_out_data;
  logic              r_proto_err;
  logic [c_RW-1:0]   w_comb;
  logic              w_pp_hs;
  logic              w_last_beat;

  assign w_pp_hs     = i_pp_valid && o_pp_ready;
  assign w_last_beat = (r_beat_cnt == 2'd3);

  // Even lanes carry slot1 and slot4 shifted up by one lane; odd lanes slot2^slot3.
  always_comb begin
    w_comb = '0;
    for (int k = 0; k < c_PW; k++) begin
      w_comb[2*k]   = w_comb[2*k] ^ r_slot1[k];
      w_comb[2*k+1] = r_slot2[k] ^ r_slot3[k];
      w_comb[2*k+2] = w_comb[2*k+2] ^ i_pp_data[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_pp_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      S_COLLECT: begin
        o_pp_ready = 1'b1;
        if (i_pp_valid && w_last_beat) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = S_COLLECT;
        end
      end
      default: w_state_nxt = S_COLLECT;
    endcase
    if (i_abort) begin
      w_state_nxt = S_COLLECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt  <= 2'd0;
      r_out_data  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      // pp_last must be set exactly on the fourth beat; a mismatch is sticky.
      if (w_pp_hs && (i_pp_last != w_last_beat)) begin
        r_proto_err <= 1'b1;
      end
      if (i_abort) begin
        r_beat_cnt <= 2'd0;
      end else if (w_pp_hs) begin
        if (w_last_beat) begin
          r_beat_cnt <= 2'd0;
          r_out_data <= w_comb;
        end else begin
          r_beat_cnt <= r_beat_cnt + 2'd1;
        end
      end
    end
  end

  // Slots are always written before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_pp_hs && !i_abort) begin
      case (r_beat_cnt)
        2'd0:    r_slot1 <= i_pp_data;
        2'd1:    r_slot2 <= i_pp_data;
        2'd2:    r_slot3 <= i_pp_data;
        default: ;
      endcase
    end
  end

  assign o_out_data  = r_out_data;
  assign o_beat_cnt  = r_beat_cnt;
  assign o_proto_err = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_overlap_sched_117bit.sv
// tb_overlap_sched_117bit: scoreboard bench for overlap_sched_117bit with an
// independent bit-by-bit reference of the combine rule.
`default_nettype none

module tb_overlap_sched_117bit;

  logic         clk;
  logic         rst;
  logic         i_pp_valid;
  logic         o_pp_ready;
  logic [116:0] i_pp_data;
  logic         i_pp_last;
  logic         i_abort;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [234:0] o_out_data;
  logic [1:0]   o_beat_cnt;
  logic         o_proto_err;

  int           n_chk;
  int           n_pass;
  logic [234:0] exp_q[$];
  logic [234:0] mon_exp;

  overlap_sched_117bit dut (
    .clk         (clk),
    .rst         (rst),
    .i_pp_valid  (i_pp_valid),
    .o_pp_ready  (o_pp_ready),
    .i_pp_data   (i_pp_data),
    .i_pp_last   (i_pp_last),
    .i_abort     (i_abort),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_beat_cnt  (o_beat_cnt),
    .o_proto_err (o_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [234:0] got, input logic [234:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [234:0] model(input logic [116:0] a1, input logic [116:0] a2,
                                         input logic [116:0] a3, input logic [116:0] a4);
    logic [234:0] r;
    r = '0;
    for (int b = 0; b < 235; b++) begin
      int k;
      k = b / 2;
      if (b % 2 == 1) begin
        r[b] = a2[k] ^ a3[k];
      end else begin
        if (k < 117) r[b] = r[b] ^ a1[k];
        if (k > 0)   r[b] = r[b] ^ a4[k-1];
      end
    end
    return r;
  endfunction

  function automatic logic [116:0] rnd117();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[116:0];
  endfunction

  // Result monitor: a handshake is about to occur at the next rising edge.
  always @(negedge clk) begin
    if (!rst && o_out_valid && i_out_ready && !i_abort) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1'b1, 1'b0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_data", o_out_data, mon_exp);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat's handshake edge.
  task automatic send_beat(input logic [116:0] d, input logic last, input logic ab);
    int t;
    i_pp_valid = 1'b1;
    i_pp_data  = d;
    i_pp_last  = last;
    i_abort    = ab;
    t = 0;
    @(negedge clk);
    while (!o_pp_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!o_pp_ready) chk("pp_ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    i_pp_valid = 1'b0;
    i_abort    = 1'b0;
  endtask

  task automatic op(input logic [116:0] a1, input logic [116:0] a2, input logic [116:0] a3,
                    input logic [116:0] a4, input int bad, input logic [234:0] e, input bit gaps);
    logic [116:0] d[4];
    d[0] = a1; d[1] = a2; d[2] = a3; d[3] = a4;
    exp_q.push_back(e);
    for (int b = 0; b < 4; b++) begin
      send_beat(d[b], (b == 3) ^ (b + 1 == bad), 1'b0);
      if (gaps && b < 3) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    chk("latency_out_valid", o_out_valid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || o_out_valid) && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", (exp_q.size() != 0) || o_out_valid, 1'b0);
  endtask

  initial begin
    logic [116:0] x1, x2, x3, x4, ones;
    logic [234:0] e;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    i_pp_valid = 1'b0;
    i_pp_data = '0;
    i_pp_last = 1'b0;
    i_abort = 1'b0;
    i_out_ready = 1'b1;
    ones = '1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_beat_cnt", o_beat_cnt, 2'd0);
    chk("rst_out_valid", o_out_valid, 1'b0);
    chk("rst_out_data", o_out_data, '0);
    chk("rst_proto_err", o_proto_err, 1'b0);
    chk("rst_pp_ready", o_pp_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed single-bit and lane patterns, expectations as constants.
    op(117'd1, '0, '0, '0, 0, 235'd1, 1'b0);
    drain();
    chk("retain_out_data", o_out_data, 235'd1);
    chk("proto_err_clean", o_proto_err, 1'b0);
    op('0, '0, '0, 117'd1 << 116, 0, 235'd1 << 234, 1'b0);
    op('0, ones, ones, '0, 0, 235'd0, 1'b0);
    op('0, 117'd1 << 5, '0, '0, 0, 235'd1 << 11, 1'b0);
    op(117'd1 << 3, '0, '0, 117'd1 << 2, 0, 235'd0, 1'b0);
    op(117'd1 << 3, '0, '0, '0, 0, 235'd1 << 6, 1'b0);
    drain();

    // Backpressure with the next op's first beat waiting.
    x1 = rnd117(); x2 = rnd117(); x3 = rnd117(); x4 = rnd117();
    e = model(x1, x2, x3, x4);
    i_out_ready = 1'b0;
    op(x1, x2, x3, x4, 0, e, 1'b0);
    x1 = rnd117(); x2 = rnd117(); x3 = rnd117(); x4 = rnd117();
    i_pp_valid = 1'b1;
    i_pp_data = x1;
    i_pp_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_out_valid", o_out_valid, 1'b1);
      chk("bp_out_data", o_out_data, e);
      chk("bp_pp_ready", o_pp_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    exp_q.push_back(model(x1, x2, x3, x4));
    i_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_ready_after", o_pp_ready, 1'b1);
    @(negedge clk);
    chk("bp_beat_accepted", o_beat_cnt, 2'd1);
    i_pp_valid = 1'b0;
    @(posedge clk);
    #1;
    send_beat(x2, 1'b0, 1'b0);
    send_beat(x3, 1'b0, 1'b0);
    send_beat(x4, 1'b1, 1'b0);
    drain();

    // Protocol error on beat 2; survives abort.
    x1 = rnd117(); x2 = rnd117(); x3 = rnd117(); x4 = rnd117();
    op(x1, x2, x3, x4, 2, model(x1, x2, x3, x4), 1'b0);
    drain();
    chk("proto_err_set", o_proto_err, 1'b1);
    i_abort = 1'b1;
    @(posedge clk);
    #1;
    i_abort = 1'b0;
    @(negedge clk);
    chk("proto_err_after_abort", o_proto_err, 1'b1);
    @(posedge clk);
    #1;

    // Abort coincident with beat 3.
    send_beat(rnd117(), 1'b0, 1'b0);
    send_beat(rnd117(), 1'b0, 1'b0);
    send_beat(rnd117(), 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_beat_cnt", o_beat_cnt, 2'd0);
    chk("flush_out_valid", o_out_valid, 1'b0);
    @(posedge clk);
    #1;
    x1 = rnd117(); x2 = rnd117(); x3 = rnd117(); x4 = rnd117();
    op(x1, x2, x3, x4, 0, model(x1, x2, x3, x4), 1'b0);
    drain();

    // Asynchronous reset between edges with two beats held.
    send_beat(rnd117(), 1'b0, 1'b0);
    send_beat(rnd117(), 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_reset_beat_cnt", o_beat_cnt, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_beat_cnt", o_beat_cnt, 2'd0);
    chk("async_out_valid", o_out_valid, 1'b0);
    chk("async_out_data", o_out_data, '0);
    chk("async_proto_err", o_proto_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic with idle gaps between beats.
    for (int n = 0; n < 24; n++) begin
      x1 = rnd117(); x2 = rnd117(); x3 = rnd117(); x4 = rnd117();
      op(x1, x2, x3, x4, 0, model(x1, x2, x3, x4), 1'b1);
    end
    drain();
    chk("final_proto_err", o_proto_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/overlap_sched_117bit.md
OVERLAP_SCHED_117BIT -- requirements
Module: overlap_sched_117bit

Interface
- REQ-001: Parameter n, default 118, is the sub-product order; partial-product width is n-1 (117) and result width is 2n-1 (235); the design SHALL support only n=118.
- REQ-002: clk  input  1  sole clock, rising edge.
- REQ-003: rst  input  1  reset, asynchronous, active-high.
- REQ-004: pp_valid  input  1  partial-product beat valid.
- REQ-005: pp_ready  output  1  block accepts a beat this cycle.
- REQ-006: pp_data  input  117  partial-product beat; beats arrive in order B2_in1, B2_in2, B2_in3, B2_in4.
- REQ-007: pp_last  input  1  sender marks the 4th beat.
- REQ-008: abort  input  1  synchronous flush request.
- REQ-009: out_valid  output  1  combined result valid.
- REQ-010: out_ready  input  1  downstream accepts the result.
- REQ-011: out_data  output  235  overlap-combined product.
- REQ-012: beat_cnt  output  2  number of beats held for the current operation (0..3).
- REQ-013: proto_err  output  1  sticky protocol-error flag.

Function
- REQ-014: The FSM SHALL have two states: COLLECT and DONE.
- REQ-015: A handshake SHALL occur when pp_valid and pp_ready are both 1 on a rising edge.
- REQ-016: pp_ready SHALL be 1 in COLLECT and 0 in DONE; the block SHALL NOT accept the next operation's beats while a result is pending.
- REQ-017: In COLLECT, handshakes 1..3 SHALL store pp_data into slots 1..3 and increment beat_cnt.
- REQ-018: The 4th handshake SHALL register out_data from slots 1..3 plus the incoming pp_data as slot 4, move to DONE and reset beat_cnt to 0.
- REQ-019: out_valid SHALL rise the cycle after the 4th handshake, giving a latency of 1 cycle.
- REQ-020: The combine rule is as follows, with i1..i4 = slots 1..4.
  - out_data[2k] = i1[k] ^ i4[k-1] for k=0..117, where i4[-1]=0 and i1[117]=0; hence out[0]=i1[0] and out[234]=i4[116].
  - out_data[2k+1] = i2[k] ^ i3[k] for k=0..116.
  - All operations are GF(2); there are no carries.
- REQ-021: In DONE, out_valid and out_data SHALL hold stable until out_ready=1.
- REQ-022: On the out_ready handshake the block SHALL move to COLLECT and clear out_valid on the next cycle.
- REQ-023: out_data SHALL retain its last value after the result is consumed.
- REQ-024: pp_last is checked on every handshake.
  - If pp_last=1 on beats 1..3, or pp_last=0 on beat 4, proto_err SHALL set to 1 and stay set until reset.
  - The beat SHALL still be accepted and sequencing SHALL NOT change.
- REQ-025: abort=1 SHALL, on the next edge, force COLLECT, beat_cnt=0 and out_valid=0, and SHALL discard held slots.
- REQ-026: abort SHALL take priority over a simultaneous pp or out handshake; that beat or result is dropped.
- REQ-027: abort SHALL NOT clear proto_err.
- REQ-028: pp_valid=0 cycles between beats SHALL NOT affect the stored slots or beat_cnt.

Reset
- REQ-029: While rst=1, the block SHALL be in COLLECT with beat_cnt=0, out_valid=0, out_data=0 and proto_err=0; pp_ready=1 follows from COLLECT.
- REQ-030: Slot registers need not be reset, since they are always written before use.
- REQ-031: Reset asserted mid-operation SHALL discard partial beats and any pending result immediately.

Verification
- REQ-032: Single-bit mapping.
  - i1=1, i2=i3=i4=0, pp_last on beat 4 -> out_valid one cycle later with out_data=1, proto_err=0.
  - i4 = 1<<116, others 0 -> out_data = 1<<234.
- REQ-033: Odd and even lanes.
  - i2=i3=all-ones -> all odd bits 0.
  - i2 = 1<<5, i3=0 -> out_data = 1<<11.
  - i1 = 1<<3, i4 = 1<<2 -> bit 6 = 0.
- REQ-034: Backpressure: with out_ready=0 for 10 cycles after DONE -> out_valid and out_data stable and pp_ready=0 throughout; out_ready=1 -> next beat accepted the following cycle.
- REQ-035: Protocol error: pp_last=1 on beat 2 -> proto_err=1; the operation still completes after 4 beats; proto_err remains 1 after abort.
- REQ-036: Flush: abort on the same cycle as beat 3 handshake -> beat_cnt=0; the next 4 beats produce a result from the new data only.
- REQ-037: Async reset asserted while beat_cnt=2 (no clock edge needed) -> beat_cnt=0 and out_valid=0 immediately; random back-to-back traffic checked against the REQ-020 reference model.
